// File: rtl/mtc_builder_sync.sv
// MTC builder: pairs each SL candidate with its ptcalc thread result.
// Each SL slot buffers one candidate until the thread named by its process
// channel delivers a pT word, or until a programmable timeout expires. It
// then emits one registered MTC word {valid, timeout, pt, slc} on its link.
// Candidates on an out-of-range channel need no pT and pass straight through.
// Saturating counters track pre-empted candidates and unmatched pT strobes.
module mtc_builder_sync #(
    parameter int PTCALC_WIDTH = 64,
    parameter int SLC_WIDTH    = 128,
    parameter int CH_WIDTH     = 2,
    parameter int N_THREADS    = 3,
    parameter int N_SL         = 3,
    parameter int TIMEOUT      = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                                        clock,
    input  logic                                        rst,
    input  logic [N_SL-1:0]                             slc_valid,
    input  logic [N_SL-1:0][SLC_WIDTH-1:0]              slc_data,
    input  logic [N_SL-1:0][CH_WIDTH-1:0]               slc_ch,
    input  logic [N_THREADS-1:0]                        pt_valid,
    input  logic [N_THREADS-1:0][PTCALC_WIDTH-1:0]      pt_data,
    output logic [N_SL-1:0][SLC_WIDTH+PTCALC_WIDTH+1:0] mtc,
    output logic [CNT_WIDTH-1:0]                        preempt_cnt,
    output logic [CNT_WIDTH-1:0]                        orphan_cnt
);

    localparam int MTC_WIDTH = SLC_WIDTH + PTCALC_WIDTH + 2;
    localparam int TMR_WIDTH = 8;               // TIMEOUT is limited to 1..255
    localparam int SUM_WIDTH = CNT_WIDTH + 8;   // counter plus one cycle's increments

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Per-slot control state
    state_t                 state  [N_SL];
    logic [TMR_WIDTH-1:0]   timer  [N_SL];
    logic [N_SL-1:0]        bypass;     // held candidate has no thread; emit it next cycle

    // Per-slot candidate buffer
    logic [SLC_WIDTH-1:0]   slc_q  [N_SL];
    logic [CH_WIDTH-1:0]    ch_q   [N_SL];

    // Matching results for the current cycle
    logic [N_SL-1:0]         ch_ok;
    logic [N_SL-1:0]         eligible;
    logic [N_SL-1:0]         slot_match;
    logic [PTCALC_WIDTH-1:0] slot_pt [N_SL];
    logic [N_THREADS-1:0]    taken;
    logic [SUM_WIDTH-1:0]    orphan_n;
    logic [SUM_WIDTH-1:0]    preempt_n;

    function automatic logic [MTC_WIDTH-1:0] mk_word(
        input logic                    to,
        input logic [PTCALC_WIDTH-1:0] pt,
        input logic [SLC_WIDTH-1:0]    slc
    );
        return {1'b1, to, pt, slc};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [SUM_WIDTH-1:0] inc
    );
        logic [SUM_WIDTH-1:0] sum;
        sum = SUM_WIDTH'(cnt) + inc;
        if (sum > SUM_WIDTH'({CNT_WIDTH{1'b1}})) begin
            return '1;
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    // Route each thread strobe to the lowest-index waiting slot on its channel
    // and count the strobes that find no slot plus the slots being pre-empted.
    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    always_comb begin
        taken      = '0;
        slot_match = '0;
        orphan_n   = '0;
        preempt_n  = '0;
        for (int i = 0; i < N_SL; i++) begin
            slot_pt[i]  = '0;
            ch_ok[i]    = int'(slc_ch[i]) < N_THREADS;
            // A slot being pre-empted gives up its claim on this cycle's strobe.
            eligible[i] = (state[i] == S_WAIT) && !bypass[i] && !slc_valid[i];
            if ((state[i] == S_WAIT) && slc_valid[i]) begin
                preempt_n = preempt_n + SUM_WIDTH'(1);
            end
        end
        for (int i = 0; i < N_SL; i++) begin
            for (int t = 0; t < N_THREADS; t++) begin
                if (pt_valid[t] && !taken[t] && eligible[i] && (ch_q[i] == CH_WIDTH'(t))) begin
                    slot_match[i] = 1'b1;
                    slot_pt[i]    = pt_data[t];
                    taken[t]      = 1'b1;
                end
            end
        end
        for (int t = 0; t < N_THREADS; t++) begin
            if (pt_valid[t] && !taken[t]) begin
                orphan_n = orphan_n + SUM_WIDTH'(1);
            end
        end
    end

    // Capture every new candidate; the control FSM decides what it means.
    // NOTE: the candidate buffers are not reset: slot state gates every read, so clearing them buys nothing.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_SL; i++) begin
            if (slc_valid[i]) begin
                slc_q[i] <= slc_data[i];
                ch_q[i]  <= slc_ch[i];
            end
        end
    end

    // Per-slot IDLE/WAIT FSM with registered MTC output and error counters.
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < N_SL; i++) begin
                state[i] <= S_IDLE;
                timer[i] <= '0;
                bypass[i] <= 1'b0;
                mtc[i]   <= '0;
            end
            preempt_cnt <= '0;
            orphan_cnt  <= '0;
        end else begin
            preempt_cnt <= sat_add(preempt_cnt, preempt_n);
            orphan_cnt  <= sat_add(orphan_cnt, orphan_n);
            for (int i = 0; i < N_SL; i++) begin
                mtc[i] <= '0;
                case (state[i])
                    S_IDLE: begin
                        if (slc_valid[i]) begin
                            if (ch_ok[i]) begin
                                state[i]  <= S_WAIT;
                                timer[i]  <= TMR_WIDTH'(TIMEOUT);
                                bypass[i] <= 1'b0;
                            end else begin
                                mtc[i] <= mk_word(1'b0, '0, slc_data[i]);
                            end
                        end
                    end
                    S_WAIT: begin
                        if (slc_valid[i]) begin
                            // Pre-emption: the old candidate leaves as a timeout word
                            // and the new one occupies the slot; a channel-less new
                            // candidate waits one cycle for the link to free up.
                            mtc[i] <= mk_word(1'b1, '0, slc_q[i]);
                            timer[i]  <= TMR_WIDTH'(TIMEOUT);
                            bypass[i] <= !ch_ok[i];
                        end else if (bypass[i]) begin
                            mtc[i]    <= mk_word(1'b0, '0, slc_q[i]);
                            bypass[i] <= 1'b0;
                            state[i]  <= S_IDLE;
                        end else if (slot_match[i]) begin
                            mtc[i]   <= mk_word(1'b0, slot_pt[i], slc_q[i]);
                            state[i] <= S_IDLE;
                        end else if (timer[i] == TMR_WIDTH'(1)) begin
                            mtc[i]   <= mk_word(1'b1, '0, slc_q[i]);
                            state[i] <= S_IDLE;
                        end else begin
                            timer[i] <= timer[i] - TMR_WIDTH'(1);
                        end
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mtc_builder_sync.sv
// Self-checking bench for mtc_builder_sync: a scoreboard of expected MTC
// words keyed by link and cycle, compared on every link every cycle.
module tb_mtc_builder_sync;

    localparam int PW  = 64;
    localparam int SW  = 128;
    localparam int CW  = 2;
    localparam int NT  = 3;
    localparam int NS  = 3;
    localparam int TO  = 16;
    localparam int CNW = 8;
    localparam int MW  = SW + PW + 2;

    logic                    clock = 1'b0;
    logic                    rst;
    logic [NS-1:0]           slc_valid;
    logic [NS-1:0][SW-1:0]   slc_data;
    logic [NS-1:0][CW-1:0]   slc_ch;
    logic [NT-1:0]           pt_valid;
    logic [NT-1:0][PW-1:0]   pt_data;
    logic [NS-1:0][MW-1:0]   mtc;
    logic [CNW-1:0]          preempt_cnt;
    logic [CNW-1:0]          orphan_cnt;

    mtc_builder_sync #(
        .PTCALC_WIDTH(PW), .SLC_WIDTH(SW), .CH_WIDTH(CW), .N_THREADS(NT),
        .N_SL(NS), .TIMEOUT(TO), .CNT_WIDTH(CNW)
    ) dut (
        .clock(clock), .rst(rst),
        .slc_valid(slc_valid), .slc_data(slc_data), .slc_ch(slc_ch),
        .pt_valid(pt_valid), .pt_data(pt_data),
        .mtc(mtc), .preempt_cnt(preempt_cnt), .orphan_cnt(orphan_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    int exp_orph = 0;
    int exp_pre  = 0;

    typedef struct {
        int            at;
        int            link;
        logic [MW-1:0] word;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            slot;
        int            ch;
        logic [SW-1:0] slc;
        int            pt_dly;   // -1: no strobe
        int            thr;
        logic [PW-1:0] pt;
        int            exp_dly;
        bit            exp_to;
        logic [PW-1:0] exp_pt;
        int            orph;
    } vec_t;
    vec_t rows [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [MW-1:0] mk(input bit to, input logic [PW-1:0] pt, input logic [SW-1:0] slc);
        return {1'b1, to, pt, slc};
    endfunction

    task automatic sb_push(input int link, input logic [MW-1:0] word, input int at);
        sb.push_back('{at, link, word});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        slc_valid = '0;
        pt_valid  = '0;
    endtask

    task automatic drive_slc(input int slot, input int ch, input logic [SW-1:0] d);
        slc_valid[slot] = 1'b1;
        slc_ch[slot]    = CW'(ch);
        slc_data[slot]  = d;
    endtask

    task automatic drive_pt(input int t, input logic [PW-1:0] d);
        pt_valid[t] = 1'b1;
        pt_data[t]  = d;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, " preempt_cnt"}, 256'(preempt_cnt), 256'((exp_pre > 255) ? 255 : exp_pre));
        check({tag, " orphan_cnt"},  256'(orphan_cnt),  256'(exp_orph));
    endtask

    // Every link, every cycle: expected word from the scoreboard, else zero.
    always @(negedge clock) begin
        logic [MW-1:0] ew;
        if (mon_en) begin
            for (int l = 0; l < NS; l++) begin
                ew = '0;
                for (int k = 0; k < sb.size(); k++) begin
                    if (sb[k].at == cyc && sb[k].link == l) begin
                        ew = sb[k].word;
                        sb.delete(k);
                        break;
                    end
                end
                check($sformatf("mtc[%0d]@%0d", l, cyc), 256'(mtc[l]), 256'(ew));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t0;

        rows[0] = '{0, 1, 128'hA5,             4, 1, 64'h3C,   5, 1'b1 ^ 1'b1, 64'h3C,   0};
        rows[1] = '{1, 2, 128'h1111_2222,      -1, 0, 64'h0,   17, 1'b1,        64'h0,    0};
        rows[2] = '{1, 2, 128'h2222_3333,      16, 2, 64'hBEEF, 17, 1'b0,       64'hBEEF, 0};
        rows[3] = '{2, 3, 128'h33,             -1, 0, 64'h0,    1, 1'b0,        64'h0,    0};
        rows[4] = '{0, 0, {64'hDEAD_BEEF, 64'hCAFE}, 1, 0, 64'h5555, 2, 1'b0,  64'h5555, 0};
        rows[5] = '{2, 1, 128'h66,              2, 0, 64'h77,  17, 1'b1,        64'h0,    1};
        rows[6] = '{1, 0, 128'h88,              0, 0, 64'h99,  17, 1'b1,        64'h0,    1};
        rows[7] = '{2, 2, 128'hAA,             15, 2, 64'hCC,  16, 1'b0,        64'hCC,   0};

        rst = 1'b1;
        slc_valid = '0; slc_data = '0; slc_ch = '0;
        pt_valid  = '0; pt_data  = '0;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        check_cnts("reset");

        // Table-driven single-slot cases: match, timeout boundary, invalid channel, wrong thread
        for (int r = 0; r < 8; r++) begin
            t0 = cyc;
            drive_slc(rows[r].slot, rows[r].ch, rows[r].slc);
            sb_push(rows[r].slot, mk(rows[r].exp_to, rows[r].exp_pt, rows[r].slc), t0 + rows[r].exp_dly);
            for (int k = 0; k <= rows[r].exp_dly + 1; k++) begin
                if (k == rows[r].pt_dly) drive_pt(rows[r].thr, rows[r].pt);
                tick();
            end
            exp_orph += rows[r].orph;
            check_cnts($sformatf("row%0d", r));
        end

        // Shared thread: one strobe fills the lowest slot only
        drive_slc(0, 0, 128'h5000);
        drive_slc(2, 0, 128'h5002);
        tick();
        tick();
        drive_pt(0, 64'hA1);
        sb_push(0, mk(1'b0, 64'hA1, 128'h5000), cyc + 1);
        tick();
        drive_pt(0, 64'hA2);
        sb_push(2, mk(1'b0, 64'hA2, 128'h5002), cyc + 1);
        tick();
        tick();
        check_cnts("shared");

        // Different threads match different slots in the same cycle
        drive_slc(0, 1, 128'h6000);
        drive_slc(1, 2, 128'h6001);
        tick();
        drive_pt(1, 64'hB1);
        drive_pt(2, 64'hB2);
        sb_push(0, mk(1'b0, 64'hB1, 128'h6000), cyc + 1);
        sb_push(1, mk(1'b0, 64'hB2, 128'h6001), cyc + 1);
        tick();
        tick();
        check_cnts("parallel");

        // Orphans with all slots idle
        drive_pt(1, 64'h1);
        exp_orph += 1;
        tick();
        tick();
        check_cnts("orphan1");
        drive_pt(0, 64'h1); drive_pt(1, 64'h2); drive_pt(2, 64'h3);
        exp_orph += 3;
        tick();
        tick();
        check_cnts("orphan3");

        // Pre-emption beats a simultaneous match to the old candidate
        drive_slc(0, 1, 128'h7000);
        tick();
        tick();
        drive_slc(0, 2, 128'h7001);
        drive_pt(1, 64'h123);
        sb_push(0, mk(1'b1, '0, 128'h7000), cyc + 1);
        exp_pre += 1;
        exp_orph += 1;
        tick();
        check_cnts("preempt");
        drive_pt(2, 64'h456);
        sb_push(0, mk(1'b0, 64'h456, 128'h7001), cyc + 1);
        tick();
        tick();

        // Pre-empted slot's strobe falls through to another waiting slot
        drive_slc(0, 1, 128'h7100);
        drive_slc(1, 1, 128'h7101);
        tick();
        drive_slc(0, 0, 128'h7102);
        drive_pt(1, 64'h789);
        sb_push(0, mk(1'b1, '0, 128'h7100), cyc + 1);
        sb_push(1, mk(1'b0, 64'h789, 128'h7101), cyc + 1);
        exp_pre += 1;
        tick();
        drive_pt(0, 64'hABC);
        sb_push(0, mk(1'b0, 64'hABC, 128'h7102), cyc + 1);
        tick();
        tick();
        check_cnts("fallthrough");

        // Pre-emption by a channel-less candidate: two words on consecutive cycles
        drive_slc(1, 0, 128'h7200);
        tick();
        drive_slc(1, 3, 128'h7201);
        sb_push(1, mk(1'b1, '0, 128'h7200), cyc + 1);
        sb_push(1, mk(1'b0, '0, 128'h7201), cyc + 2);
        exp_pre += 1;
        tick();
        tick();
        tick();
        check_cnts("preempt_inv");

        // 300 back-to-back pre-emptions saturate the counter
        drive_slc(0, 0, 128'h0);
        tick();
        for (int k = 1; k <= 300; k++) begin
            drive_slc(0, 0, SW'(k));
            sb_push(0, mk(1'b1, '0, SW'(k - 1)), cyc + 1);
            tick();
        end
        exp_pre += 300;
        check_cnts("saturate");

        // Reset mid-WAIT discards the held candidate
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pre  = 0;
        exp_orph = 0;
        check_cnts("midreset");
        drive_pt(0, 64'hF00D);
        exp_orph = 1;
        tick();
        tick();
        check_cnts("post_reset");
        for (int k = 0; k < TO + 4; k++) tick();

        check("scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
